// File: rtl/layer_pkg.sv
// Shared types and helpers for the layer_feeder block: FSM state encoding,
// the debug snapshot struct and the counter-width helper.
package layer_pkg;

  typedef enum logic [1:0] {
    S_LOAD_W = 2'd0,
    S_LOAD_I = 2'd1,
    S_SETTLE = 2'd2,
    S_OUT    = 2'd3
  } feeder_state_t;

  typedef struct packed {
    feeder_state_t state;
    logic          reload_pend;
    logic          wt_idle;
    logic          in_idle;
  } feeder_dbg_t;

  // A counter for n slots needs at least one bit even when n is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_feeder_s2p.sv
// serial_to_parallel: collects N serial beats of W bits into one packed bus,
// slot k at bits [k*W +: W]. Supports a whole-bus parallel load.
module serial_to_parallel
  import layer_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_valid,
  input  logic           i_en,
  input  logic [W-1:0]   i_data,
  input  logic           i_load,
  input  logic [N*W-1:0] i_load_data,
  output logic [N*W-1:0] o_bus,
  output logic           o_at_last,
  output logic           o_idle
);

  localparam int CW = cnt_w(N);

  logic [CW-1:0]  r_cnt;
  logic [N*W-1:0] r_bus;
  logic           w_accept;
  logic           w_at_last;

  assign w_accept  = i_valid & i_en;
  assign w_at_last = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_bus <= '0;
    end else if (i_load) begin
      r_bus <= i_load_data;
    end else if (w_accept) begin
      for (int s = 0; s < N; s++) begin
        if (r_cnt == CW'(s)) r_bus[s*W +: W] <= i_data;
      end
      // Counter wraps so the next load starts at slot 0 without a clear.
      r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
    end
  end

  assign o_bus     = r_bus;
  assign o_at_last = w_at_last;
  assign o_idle    = (r_cnt == '0);

endmodule

// File: rtl/layer_feeder.sv
// layer_feeder: serial weight/input loader and result capture around `layer`.
// Optional LAYER_FEEDER_DBUF_EN adds a shadow input buffer filled during SETTLE/OUT.
module layer_feeder
  import layer_pkg::*;
#(
  parameter int LENGHT_I   = 2,
  parameter int LENGHT_O   = 1,
  parameter int WIDTH_W    = 9,
  parameter int WIDTH_I    = 1,
  parameter int WIDTH_O    = 10,
  parameter int SETTLE_CYC = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wt_valid,
  output logic                                 wt_ready,
  input  logic [WIDTH_W-1:0]                   wt_data,
  input  logic                                 wt_reload,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH_I-1:0]                   in_data,
  output logic [LENGHT_I*LENGHT_O*WIDTH_W-1:0] w_o,
  output logic [LENGHT_I*WIDTH_I-1:0]          x_o,
  input  logic [LENGHT_O*WIDTH_O-1:0]          y_i,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LENGHT_O*WIDTH_O-1:0]          out_data,
  output logic                                 busy,
  output feeder_dbg_t                          o_dbg
);

  localparam int N_W = LENGHT_I * LENGHT_O;
  localparam int XW  = LENGHT_I * WIDTH_I;
  localparam int SW  = cnt_w(SETTLE_CYC);

  // Handshakes: a beat moves on a rising edge where valid && ready; ready is
  // a function of state only, never of valid, and valid must hold until taken.
  feeder_state_t              r_state;
  feeder_state_t              w_next;
  logic                       r_armed;
  logic                       r_reload;
  logic [SW-1:0]              r_settle_cnt;
  logic                       r_out_valid;
  logic [LENGHT_O*WIDTH_O-1:0] r_out_data;

  logic          w_wt_en, w_wt_at_last, w_wt_idle;
  logic          w_in_en, w_in_at_last, w_in_idle;
  logic          w_sh_en, w_copy;
  logic          w_settle_load, w_capture, w_hs;
  logic [XW-1:0] w_sh_bus;

`ifdef LAYER_FEEDER_DBUF_EN
  logic w_sh_at_last, w_sh_idle, r_sh_full;

  serial_to_parallel #(.N(LENGHT_I), .W(WIDTH_I)) u_in_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (in_valid),
    .i_en        (w_sh_en),
    .i_data      (in_data),
    .i_load      (1'b0),
    .i_load_data ('0),
    .o_bus       (w_sh_bus),
    .o_at_last   (w_sh_at_last),
    .o_idle      (w_sh_idle)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_sh_full <= 1'b0;
    else if (w_copy)                            r_sh_full <= 1'b0;
    else if (w_sh_en && in_valid && w_sh_at_last) r_sh_full <= 1'b1;
  end
`else
  assign w_sh_bus = '0;
`endif

  serial_to_parallel #(.N(N_W), .W(WIDTH_W)) u_wt_s2p (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (wt_valid),
    .i_en        (w_wt_en),
    .i_data      (wt_data),
    .i_load      (1'b0),
    .i_load_data ('0),
    .o_bus       (w_o),
    .o_at_last   (w_wt_at_last),
    .o_idle      (w_wt_idle)
  );

  serial_to_parallel #(.N(LENGHT_I), .W(WIDTH_I)) u_in_s2p (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (in_valid),
    .i_en        (w_in_en),
    .i_data      (in_data),
    .i_load      (w_copy),
    .i_load_data (w_sh_bus),
    .o_bus       (x_o),
    .o_at_last   (w_in_at_last),
    .o_idle      (w_in_idle)
  );

  always_comb begin
    w_next        = r_state;
    w_wt_en       = 1'b0;
    w_in_en       = 1'b0;
    w_sh_en       = 1'b0;
    w_copy        = 1'b0;
    w_settle_load = 1'b0;
    w_capture     = 1'b0;
    w_hs          = 1'b0;
    case (r_state)
      S_LOAD_W: begin
        // r_armed keeps wt_ready low until the first edge after reset release.
        w_wt_en = r_armed;
        if (r_armed && wt_valid && w_wt_at_last) w_next = S_LOAD_I;
      end
      S_LOAD_I: begin
`ifdef LAYER_FEEDER_DBUF_EN
        if (r_sh_full) begin
          w_copy        = 1'b1;
          w_settle_load = 1'b1;
          w_next        = S_SETTLE;
        end else if (!w_sh_idle) begin
          w_sh_en = 1'b1;
        end else begin
          w_in_en = 1'b1;
          if (in_valid && w_in_at_last) begin
            w_settle_load = 1'b1;
            w_next        = S_SETTLE;
          end
        end
`else
        w_in_en = 1'b1;
        if (in_valid && w_in_at_last) begin
          w_settle_load = 1'b1;
          w_next        = S_SETTLE;
        end
`endif
      end
      S_SETTLE: begin
`ifdef LAYER_FEEDER_DBUF_EN
        w_sh_en = !r_sh_full;
`endif
        if (r_settle_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = S_OUT;
        end
      end
      S_OUT: begin
`ifdef LAYER_FEEDER_DBUF_EN
        w_sh_en = !r_sh_full;
`endif
        w_hs = r_out_valid && out_ready;
        if (w_hs) begin
          if (r_reload || wt_reload) begin
            w_next = S_LOAD_W;
`ifdef LAYER_FEEDER_DBUF_EN
          end else if (r_sh_full) begin
            w_copy        = 1'b1;
            w_settle_load = 1'b1;
            w_next        = S_SETTLE;
`endif
          end else begin
            w_next = S_LOAD_I;
          end
        end
      end
      default: w_next = S_LOAD_W;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD_W;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed      <= 1'b0;
      r_reload     <= 1'b0;
      r_settle_cnt <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
    end else begin
      r_armed <= 1'b1;
      // Requests arriving while weights are already loading are dropped.
      if (w_next == S_LOAD_W && r_state != S_LOAD_W) r_reload <= 1'b0;
      else if (wt_reload && r_state != S_LOAD_W)     r_reload <= 1'b1;
      if (w_settle_load)
        r_settle_cnt <= SW'(SETTLE_CYC - 1);
      else if (r_state == S_SETTLE && r_settle_cnt != '0)
        r_settle_cnt <= r_settle_cnt - SW'(1);
      if (w_capture) begin
        r_out_data  <= y_i;
        r_out_valid <= 1'b1;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign wt_ready  = w_wt_en;
  assign in_ready  = w_in_en | w_sh_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifdef LAYER_FEEDER_DBUF_EN
  assign busy = !(r_state == S_LOAD_I && w_in_idle && w_sh_idle && !r_sh_full);
`else
  assign busy = !(r_state == S_LOAD_I && w_in_idle);
`endif

  assign o_dbg = '{state: r_state, reload_pend: r_reload, wt_idle: w_wt_idle, in_idle: w_in_idle};

endmodule

// File: tb/tb_layer_feeder.sv
// Directed bench for layer_feeder at default parameters: vector table of
// inferences plus hand sequences for stall, reload timing, reset and shadow buffer.
module tb_layer_feeder;
  import layer_pkg::*;

`ifdef LAYER_FEEDER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wt_valid = 1'b0, wt_ready, wt_reload = 1'b0;
  logic [8:0]  wt_data = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [0:0]  in_data = '0;
  logic [17:0] w_o;
  logic [1:0]  x_o;
  logic [9:0]  y_i = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [9:0]  out_data;
  logic        busy;
  feeder_dbg_t dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  layer_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data), .wt_reload(wt_reload),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_o(w_o), .x_o(x_o), .y_i(y_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .o_dbg(dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker / drivers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_wt(input logic [8:0] d);
    int n = 0;
    wt_valid = 1'b1;
    wt_data  = d;
    while (!wt_ready && n < 40) begin tick(); n++; end
    check("wt_ready_wait", wt_ready, 1);
    tick();
    wt_valid = 1'b0;
  endtask

  task automatic send_in(input logic d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin tick(); n++; end
    check("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    logic [31:0] e;
    while (!out_valid && n < 40) begin tick(); n++; end
    check({name, "_valid"}, out_valid, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({name, "_data"}, out_data, e);
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_cleared"}, out_valid, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        reload;
    logic [8:0]  w0, w1;
    logic        x0, x1;
    logic [9:0]  y;
    logic [17:0] exp_w;
    logic [1:0]  exp_x;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic nr;
    tbl[0] = '{1'b1, 9'd3,   9'd5,   1'b1, 1'b1, 10'h123, {9'd5, 9'd3},     2'b11};
    tbl[1] = '{1'b0, 9'd0,   9'd0,   1'b0, 1'b1, 10'h3FF, {9'd5, 9'd3},     2'b10};
    tbl[2] = '{1'b1, 9'h1FF, 9'h000, 1'b1, 1'b0, 10'h000, {9'h000, 9'h1FF}, 2'b01};
    tbl[3] = '{1'b0, 9'd0,   9'd0,   1'b0, 1'b0, 10'h2AA, {9'h000, 9'h1FF}, 2'b00};

    // Reset values
    tick(); tick();
    check("rst_wt_ready", wt_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 1);
    check("rst_w_o", w_o, 0);
    check("rst_x_o", x_o, 0);
    check("rst_out_data", out_data, 0);
    check("rst_reload", dbg.reload_pend, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_wt_ready", wt_ready, 1);
    check("post_rst_state", dbg.state, S_LOAD_W);

    for (int i = 0; i < 4; i++) begin
      nr = (i < 3) ? tbl[i+1].reload : 1'b0;
      if (tbl[i].reload) begin
        check("tbl_start_state_w", dbg.state, S_LOAD_W);
        send_wt(tbl[i].w0);
        send_wt(tbl[i].w1);
      end else begin
        check("tbl_start_state_i", dbg.state, S_LOAD_I);
        check("tbl_wt_ready_low", wt_ready, 0);
        check("tbl_idle_busy", busy, 0);
      end
      check("tbl_w_o", w_o, tbl[i].exp_w);
      y_i = tbl[i].y;
      exp_q.push_back({22'b0, tbl[i].y});
      send_in(tbl[i].x0);
      check("tbl_busy_partial", busy, 1);
      send_in(tbl[i].x1);
      check("tbl_x_o", x_o, tbl[i].exp_x);
      // Latency: capture lands SETTLE_CYC edges after the last input beat.
      check("tbl_lat0", out_valid, 0);
      check("tbl_settle_state", dbg.state, S_SETTLE);
      wt_reload = nr;
      tick();
      wt_reload = 1'b0;
      check("tbl_lat1", out_valid, 0);
      check("tbl_in_ready_settle", in_ready, DBUF);
      check("tbl_reload_pend", dbg.reload_pend, nr);
      tick();
      check("tbl_lat2", out_valid, 1);
      wait_out("tbl_out");
      handshake("tbl");
      check("tbl_next_state", dbg.state, nr ? S_LOAD_W : S_LOAD_I);
      check("tbl_next_wt_ready", wt_ready, nr);
      check("tbl_w_o_hold", w_o, tbl[i].exp_w);
    end

    // Consumer stalls for 10 cycles: result and input bus must hold.
    y_i = 10'h155;
    exp_q.push_back(32'h155);
    send_in(1'b1);
    send_in(1'b0);
    wait_out("stall_out");
    y_i = 10'h0AA;
    in_valid = !DBUF;
    in_data  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("stall_out_data", out_data, 10'h155);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, DBUF);
      check("stall_x_o", x_o, 2'b01);
    end
    in_valid = 1'b0;
    handshake("stall");
    check("stall_next_state", dbg.state, S_LOAD_I);

    // Reload pulse in the same cycle as the output handshake is honoured.
    y_i = 10'h201;
    exp_q.push_back(32'h201);
    send_in(1'b1);
    send_in(1'b1);
    wait_out("hsrl_out");
    wt_reload = 1'b1;
    handshake("hsrl");
    wt_reload = 1'b0;
    check("hsrl_state", dbg.state, S_LOAD_W);
    check("hsrl_wt_ready", wt_ready, 1);
    check("hsrl_reload_cleared", dbg.reload_pend, 0);

    // Reload during weight load is ignored and does not restart the load.
    send_wt(9'h0F0);
    wt_reload = 1'b1;
    tick();
    wt_reload = 1'b0;
    check("ign_state_mid", dbg.state, S_LOAD_W);
    send_wt(9'h00F);
    check("ign_state_done", dbg.state, S_LOAD_I);
    check("ign_w_o", w_o, {9'h00F, 9'h0F0});
    y_i = 10'h3C3;
    exp_q.push_back(32'h3C3);
    send_in(1'b0);
    send_in(1'b1);
    wait_out("ign_out");
    handshake("ign");
    check("ign_next_state", dbg.state, S_LOAD_I);
    check("ign_wt_ready", wt_ready, 0);

    // Reset after one of two weight beats discards everything.
    wt_reload = 1'b1;
    tick();
    wt_reload = 1'b0;
    y_i = 10'h011;
    exp_q.push_back(32'h011);
    send_in(1'b1);
    send_in(1'b0);
    wait_out("rm_out");
    handshake("rm");
    check("rm_state_w", dbg.state, S_LOAD_W);
    send_wt(9'h1AA);
    check("rm_w_o_partial", w_o, {9'h00F, 9'h1AA});
    #2 rst_n = 1'b0;
    #1;
    check("rm_w_o", w_o, 0);
    check("rm_x_o", x_o, 0);
    check("rm_out_data", out_data, 0);
    check("rm_out_valid", out_valid, 0);
    check("rm_wt_ready", wt_ready, 0);
    check("rm_in_ready", in_ready, 0);
    check("rm_busy", busy, 1);
    check("rm_wt_idle", dbg.wt_idle, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rm_wt_ready_rel", wt_ready, 1);
    send_wt(9'h003);
    check("rm_still_loading", dbg.state, S_LOAD_W);
    send_wt(9'h004);
    check("rm_load_done", dbg.state, S_LOAD_I);
    check("rm_w_o_new", w_o, {9'h004, 9'h003});

`ifdef LAYER_FEEDER_DBUF_EN
    // Second input vector streamed into the shadow while the first settles.
    y_i = 10'h0F0;
    exp_q.push_back(32'h0F0);
    send_in(1'b1);
    send_in(1'b1);
    check("db_in_ready_settle", in_ready, 1);
    send_in(1'b0);
    send_in(1'b0);
    check("db_x_o_first", x_o, 2'b11);
    wait_out("db_out1");
    y_i = 10'h00F;
    exp_q.push_back(32'h00F);
    handshake("db1");
    check("db_x_o_copied", x_o, 2'b00);
    check("db_state_settle", dbg.state, S_SETTLE);
    tick();
    check("db_lat1", out_valid, 0);
    tick();
    check("db_lat2", out_valid, 1);
    wait_out("db_out2");
    handshake("db2");
    check("db_final_state", dbg.state, S_LOAD_I);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
